// File: rtl/alu_issue_stage.sv
// Issue stage in front of the combinational ALU: holds operands stable, waits an
// op-dependent settle time, then captures the ALU result and presents it downstream.
module alu_issue_stage #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ADDSUB_WAIT = 1,
  parameter int unsigned MULDIV_WAIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_z,
  output logic             div_zero,
  output logic             busy
);

  localparam int unsigned MAX_WAIT = (MULDIV_WAIT > ADDSUB_WAIT) ? MULDIV_WAIT : ADDSUB_WAIT;
  localparam int unsigned CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;
  localparam logic [2:0] OP_MOD = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] out_c_q, out_c_d;
  logic             out_z_q, out_z_d;
  logic             div_zero_q, div_zero_d;

  logic in_ready_c;
  logic accept_c;
  logic is_muldiv_c;
  logic is_divmod_c;

  assign in_ready_c  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept_c    = in_valid && in_ready_c;
  assign is_muldiv_c = (in_op == OP_MUL) || (in_op == OP_DIV) || (in_op == OP_MOD);
  assign is_divmod_c = (in_op == OP_DIV) || (in_op == OP_MOD);

  // Next-state: accept (incl. same-edge handoff from DONE), settle countdown, capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    out_c_d    = out_c_q;
    out_z_d    = out_z_q;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
        if (accept_c) begin
          alu_a_d  = in_a;
          alu_b_d  = in_b;
          alu_op_d = in_op;
          if (is_divmod_c && (in_b == '0)) begin
            // Divide/modulo by zero never reaches the ALU settle window
            out_c_d    = '1;
            out_z_d    = 1'b0;
            div_zero_d = 1'b1;
            state_d    = DONE;
          end else begin
            cnt_d   = is_muldiv_c ? CNT_W'(MULDIV_WAIT) : CNT_W'(ADDSUB_WAIT);
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out_c_d    = alu_c;
          out_z_d    = alu_z;
          div_zero_d = 1'b0;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      out_c_q    <= '0;
      out_z_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      out_c_q    <= out_c_d;
      out_z_q    <= out_z_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign out_c     = out_c_q;
  assign out_z     = out_z_q;
  assign div_zero  = div_zero_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule
